// File: rtl/wb_interconnect_n.sv
// Single-master, N-slave classic Wishbone interconnect: registered range decode, error termination
// and fault-address capture. Defining WB_ICN_TIMEOUT_EN adds a no-ack timeout in ACTIVE.
module wb_interconnect_n #(
   parameter int                    N           = 4,
   parameter int                    ADDR_W      = 32,
   parameter int                    DATA_W      = 32,
   parameter logic [2*N*ADDR_W-1:0] ADDR_RANGES = {32'h0000_0000, 32'h0000_1000,
                                                   32'h0000_1000, 32'h0000_2000,
                                                   32'h0000_2000, 32'h0000_3000,
                                                   32'h0000_3000, 32'h0000_4000},
   parameter int                    TIMEOUT     = 255
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  m_cyc_in,
   input  logic                  m_stb_in,
   input  logic                  m_we_in,
   input  logic [ADDR_W-1:0]     m_adr_in,
   input  logic [DATA_W-1:0]     m_dat_in,
   input  logic [DATA_W/8-1:0]   m_sel_in,
   output logic [DATA_W-1:0]     m_dat_out,
   output logic                  m_ack_out,
   output logic                  m_err_out,
   output logic [N-1:0]          s_cyc_out,
   output logic [N-1:0]          s_stb_out,
   output logic                  s_we_out,
   output logic [ADDR_W-1:0]     s_adr_out,
   output logic [DATA_W-1:0]     s_dat_out,
   output logic [DATA_W/8-1:0]   s_sel_out,
   input  logic [N*DATA_W-1:0]   s_dat_in,
   input  logic [N-1:0]          s_ack_in,
   input  logic [N-1:0]          s_err_in,
   output logic [ADDR_W-1:0]     err_addr_out,
   output logic [1:0]            err_cause_out
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ERROR  = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [IDX_W-1:0]    idx_r, idx_s;
   logic [ADDR_W-1:0]   err_addr_r, err_addr_s;
   logic [1:0]          err_cause_r, err_cause_s;

   logic [N-1:0]        match_s;
   logic                hit_s;
   logic [IDX_W-1:0]    hit_idx_s;
   logic                slv_ack_s, slv_err_s;
   logic [DATA_W-1:0]   sel_dat_s;
   logic                to_hit_s;

   logic [N-1:0]        s_cyc_s, s_stb_s;
   logic                m_ack_s, m_err_s;
   logic [DATA_W-1:0]   m_dat_s;

   // Entry 0 sits at the MSB end of ADDR_RANGES: base first, then exclusive limit.
   function automatic logic [ADDR_W-1:0] range_base(input int i);
      range_base = ADDR_RANGES[(2*N-1-2*i)*ADDR_W +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] range_limit(input int i);
      range_limit = ADDR_RANGES[(2*N-2-2*i)*ADDR_W +: ADDR_W];
   endfunction

   // Range match per slave and lowest-index priority select.
   always_comb begin
      match_s   = '0;
      hit_s     = 1'b0;
      hit_idx_s = '0;
      for (int i = 0; i < N; i++) begin
         match_s[i] = (m_adr_in >= range_base(i)) && (m_adr_in < range_limit(i));
      end
      for (int i = 0; i < N; i++) begin
         if (match_s[i] && !hit_s) begin
            hit_s     = 1'b1;
            hit_idx_s = IDX_W'(i);
         end else begin
            hit_idx_s = hit_idx_s;
         end
      end
   end

   // Responses of the latched slave; a master that has dropped cyc no longer sees them.
   assign slv_ack_s = s_ack_in[idx_r] & m_cyc_in;
   assign slv_err_s = s_err_in[idx_r] & m_cyc_in;
   assign sel_dat_s = s_dat_in[idx_r*DATA_W +: DATA_W];

`ifdef WB_ICN_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_r;

   // A same-cycle ack or err from the slave beats the timeout.
   assign to_hit_s = (state_r == ST_ACTIVE) && m_cyc_in && (to_cnt_r == TO_W'(TIMEOUT))
                     && !slv_ack_s && !slv_err_s;

   // Wait-cycle counter: held at zero outside ACTIVE, counts unanswered ACTIVE cycles.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         to_cnt_r <= '0;
      end else if (state_r != ST_ACTIVE) begin
         to_cnt_r <= '0;
      end else if (!slv_ack_s && !slv_err_s && (to_cnt_r != TO_W'(TIMEOUT))) begin
         to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end
`else
   assign to_hit_s = 1'b0;
`endif

   // Next-state, slave select and master response.
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      err_addr_s  = err_addr_r;
      err_cause_s = err_cause_r;
      s_cyc_s     = '0;
      s_stb_s     = '0;
      m_ack_s     = 1'b0;
      m_err_s     = 1'b0;
      m_dat_s     = '0;
      case (state_r)
         ST_IDLE: begin
            if (m_cyc_in && m_stb_in) begin
               if (hit_s) begin
                  idx_s   = hit_idx_s;
                  state_s = ST_ACTIVE;
               end else begin
                  state_s = ST_ERROR;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            m_dat_s = sel_dat_s;
            if (to_hit_s) begin
               m_err_s     = 1'b1;
               err_addr_s  = m_adr_in;
               err_cause_s = 2'b11;
               state_s     = ST_IDLE;
            end else begin
               s_cyc_s[idx_r] = m_cyc_in;
               s_stb_s[idx_r] = m_stb_in;
               m_err_s        = slv_err_s;
               m_ack_s        = slv_ack_s & ~slv_err_s;
               if (!m_cyc_in) begin
                  state_s = ST_IDLE;
               end else if (slv_err_s) begin
                  err_addr_s  = m_adr_in;
                  err_cause_s = 2'b10;
                  state_s     = ST_IDLE;
               end else if (slv_ack_s) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s = ST_ACTIVE;
               end
            end
         end
         ST_ERROR: begin
            m_err_s     = 1'b1;
            err_addr_s  = m_adr_in;
            err_cause_s = 2'b01;
            state_s     = ST_IDLE;
         end
         default: begin
            idx_s   = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, latched slave index and fault registers.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         err_addr_r  <= '0;
         err_cause_r <= 2'b00;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         err_addr_r  <= err_addr_s;
         err_cause_r <= err_cause_s;
      end
   end

   // While reset is held every output is forced low, so an interrupted transfer never acks or errs.
   assign s_cyc_out     = reset_in ? s_cyc_s     : '0;
   assign s_stb_out     = reset_in ? s_stb_s     : '0;
   assign m_ack_out     = reset_in & m_ack_s;
   assign m_err_out     = reset_in & m_err_s;
   assign m_dat_out     = reset_in ? m_dat_s     : '0;
   assign s_we_out      = reset_in & m_we_in;
   assign s_adr_out     = reset_in ? m_adr_in    : '0;
   assign s_dat_out     = reset_in ? m_dat_in    : '0;
   assign s_sel_out     = reset_in ? m_sel_in    : '0;
   assign err_addr_out  = reset_in ? err_addr_r  : '0;
   assign err_cause_out = reset_in ? err_cause_r : 2'b00;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed scoreboard bench for wb_interconnect_n with three slaves (slave 2 overlaps slave 0).
// The timeout section adapts to whether WB_ICN_TIMEOUT_EN is defined.
module tb_wb_interconnect_n;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam logic [2*N*AW-1:0] RANGES = {32'h0000_0000, 32'h0000_0400,
                                           32'h0000_1000, 32'h0000_1100,
                                           32'h0000_0200, 32'h0000_0600};

   logic            clk_in = 1'b0;
   logic            reset_in = 1'b0;
   logic            m_cyc_in = 1'b0, m_stb_in = 1'b0, m_we_in = 1'b0;
   logic [AW-1:0]   m_adr_in = '0;
   logic [DW-1:0]   m_dat_in = '0;
   logic [DW/8-1:0] m_sel_in = '0;
   logic [DW-1:0]   m_dat_out;
   logic            m_ack_out, m_err_out;
   logic [N-1:0]    s_cyc_out, s_stb_out;
   logic            s_we_out;
   logic [AW-1:0]   s_adr_out;
   logic [DW-1:0]   s_dat_out;
   logic [DW/8-1:0] s_sel_out;
   logic [N*DW-1:0] s_dat_in = '0;
   logic [N-1:0]    s_ack_in = '0, s_err_in = '0;
   logic [AW-1:0]   err_addr_out;
   logic [1:0]      err_cause_out;

   typedef struct packed {
      logic          ack;
      logic          err;
      logic [DW-1:0] dat;
   } resp_t;

   resp_t sb_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   wb_interconnect_n #(.N(N), .ADDR_W(AW), .DATA_W(DW), .ADDR_RANGES(RANGES), .TIMEOUT(TO)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .m_cyc_in(m_cyc_in), .m_stb_in(m_stb_in), .m_we_in(m_we_in), .m_adr_in(m_adr_in),
      .m_dat_in(m_dat_in), .m_sel_in(m_sel_in), .m_dat_out(m_dat_out), .m_ack_out(m_ack_out),
      .m_err_out(m_err_out), .s_cyc_out(s_cyc_out), .s_stb_out(s_stb_out), .s_we_out(s_we_out),
      .s_adr_out(s_adr_out), .s_dat_out(s_dat_out), .s_sel_out(s_sel_out), .s_dat_in(s_dat_in),
      .s_ack_in(s_ack_in), .s_err_in(s_err_in), .err_addr_out(err_addr_out),
      .err_cause_out(err_cause_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_resp(input string tag);
      resp_t e;
      n_cmp++;
      assert (sb_q.size() != 0) else begin
         n_bad++;
         $error("FAIL %s: observed=response expected=no pending transfer", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, " ack"}, 64'(m_ack_out), 64'(e.ack));
         chk({tag, " err"}, 64'(m_err_out), 64'(e.err));
         chk({tag, " dat"}, 64'(m_dat_out), 64'(e.dat));
      end
   endtask

   // slv < 0 means the address is unmapped; b2b starts in the cycle right after a held-over ack.
   task automatic xfer(input string tag, input logic [31:0] adr, input logic we, input int slv,
                       input int waits, input logic ack, input logic err, input logic [31:0] rdat,
                       input logic spur, input logic hold, input logic b2b);
      resp_t        r;
      logic [N-1:0] oh;
      if (!b2b) begin
         @(posedge clk_in);
         #1;
      end
      m_cyc_in = 1'b1; m_stb_in = 1'b1; m_we_in = we; m_adr_in = adr;
      m_dat_in = ~rdat; m_sel_in = 4'hF;
      if (slv >= 0) s_dat_in[slv*DW +: DW] = rdat;
      r.ack = (slv >= 0) && ack && !err;
      r.err = (slv < 0) || err;
      r.dat = (slv >= 0) ? rdat : 32'h0;
      sb_q.push_back(r);
      @(negedge clk_in);
      chk({tag, " decode stb"}, 64'(s_stb_out), 64'd0);
      chk({tag, " decode ack/err"}, 64'({m_ack_out, m_err_out}), 64'd0);
      chk({tag, " bcast adr"}, 64'(s_adr_out), 64'(adr));
      chk({tag, " bcast we"}, 64'(s_we_out), 64'(we));
      @(posedge clk_in);
      if (slv < 0) begin
         @(negedge clk_in);
         chk({tag, " unmapped stb"}, 64'(s_stb_out), 64'd0);
         check_resp(tag);
         @(posedge clk_in);
         #1; m_cyc_in = 1'b0; m_stb_in = 1'b0;
         @(negedge clk_in);
         chk({tag, " err one cycle"}, 64'(m_err_out), 64'd0);
         chk({tag, " err_cause"}, 64'(err_cause_out), 64'd1);
         chk({tag, " err_addr"}, 64'(err_addr_out), 64'(adr));
      end else begin
         oh = '0;
         oh[slv] = 1'b1;
         for (int k = 0; k < waits; k++) begin
            #1;
            if (spur) begin
               s_ack_in = ~oh; s_err_in = ~oh;
            end
            @(negedge clk_in);
            chk({tag, " wait cyc"}, 64'(s_cyc_out), 64'(oh));
            chk({tag, " wait stb"}, 64'(s_stb_out), 64'(oh));
            chk({tag, " wait ack/err"}, 64'({m_ack_out, m_err_out}), 64'd0);
            @(posedge clk_in);
         end
         #1;
         s_ack_in = '0; s_err_in = '0;
         s_ack_in[slv] = ack; s_err_in[slv] = err;
         @(negedge clk_in);
         chk({tag, " resp stb"}, 64'(s_stb_out), 64'(oh));
         check_resp(tag);
         @(posedge clk_in);
         #1; s_ack_in = '0; s_err_in = '0;
         if (!hold) begin
            m_cyc_in = 1'b0; m_stb_in = 1'b0;
         end
         if (err) begin
            @(negedge clk_in);
            chk({tag, " slave err_cause"}, 64'(err_cause_out), 64'd2);
            chk({tag, " slave err_addr"}, 64'(err_addr_out), 64'(adr));
         end
      end
   endtask

   initial begin
      // Reset with a busy-looking master: every output must stay low.
      m_adr_in = 32'hA5A5_0000; m_cyc_in = 1'b1; m_stb_in = 1'b1; m_we_in = 1'b1;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      chk("reset cyc/stb", 64'({s_cyc_out, s_stb_out}), 64'd0);
      chk("reset ack/err", 64'({m_ack_out, m_err_out}), 64'd0);
      chk("reset bcast adr/we", 64'({s_we_out, s_adr_out}), 64'd0);
      chk("reset fault regs", 64'({err_cause_out, err_addr_out}), 64'd0);
      @(posedge clk_in);
      #1; reset_in = 1'b1; m_cyc_in = 1'b0; m_stb_in = 1'b0; m_we_in = 1'b0;

      xfer("rd 0x1004", 32'h0000_1004, 1'b0, 1, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      xfer("unmapped 0x800", 32'h0000_0800, 1'b0, -1, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      xfer("wr 0x10 ack+err", 32'h0000_0010, 1'b1, 0, 0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      xfer("rd 0x3FF", 32'h0000_03FF, 1'b0, 0, 2, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
      @(negedge clk_in);
      chk("fault hold cause", 64'(err_cause_out), 64'd2);
      chk("fault hold addr", 64'(err_addr_out), 64'h10);
      xfer("limit 0x1100", 32'h0000_1100, 1'b0, -1, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      xfer("rd 0x400 slv2", 32'h0000_0400, 1'b0, 2, 1, 1'b1, 1'b0, 32'hCAFE_0400, 1'b0, 1'b0, 1'b0);
      xfer("spurious", 32'h0000_10FF, 1'b1, 1, 3, 1'b1, 1'b0, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);

      // Overlap: 0x300 belongs to slave 0 and slave 2; master aborts while waiting.
      @(posedge clk_in);
      #1; m_cyc_in = 1'b1; m_stb_in = 1'b1; m_we_in = 1'b0; m_adr_in = 32'h0000_0300;
      @(negedge clk_in);
      chk("abort decode stb", 64'(s_stb_out), 64'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      chk("overlap cyc", 64'(s_cyc_out), 64'b001);
      chk("overlap stb", 64'(s_stb_out), 64'b001);
      @(posedge clk_in);
      #1; m_cyc_in = 1'b0; m_stb_in = 1'b0;
      @(negedge clk_in);
      chk("abort cyc/stb", 64'({s_cyc_out, s_stb_out}), 64'd0);
      chk("abort ack/err", 64'({m_ack_out, m_err_out}), 64'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      chk("abort idle ack/err", 64'({m_ack_out, m_err_out}), 64'd0);
      xfer("after abort", 32'h0000_0500, 1'b0, 2, 0, 1'b1, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 1'b0);

      // Back-to-back: strobe held through the ack, next address decoded in the following cycle.
      xfer("b2b first", 32'h0000_0020, 1'b0, 0, 0, 1'b1, 1'b0, 32'h1111_2222, 1'b0, 1'b1, 1'b0);
      xfer("b2b second", 32'h0000_1040, 1'b0, 1, 0, 1'b1, 1'b0, 32'h3333_4444, 1'b0, 1'b0, 1'b1);

      // Slave 1 never answers.
      @(posedge clk_in);
      #1; m_cyc_in = 1'b1; m_stb_in = 1'b1; m_we_in = 1'b0; m_adr_in = 32'h0000_1010;
      @(posedge clk_in);
`ifdef WB_ICN_TIMEOUT_EN
      for (int k = 1; k <= TO + 1; k++) begin
         @(negedge clk_in);
         chk("timeout err", 64'(m_err_out), 64'(k == TO + 1));
         chk("timeout cyc", 64'(s_cyc_out), (k == TO + 1) ? 64'd0 : 64'b010);
         @(posedge clk_in);
      end
      #1; m_cyc_in = 1'b0; m_stb_in = 1'b0;
      @(negedge clk_in);
      chk("timeout cause", 64'(err_cause_out), 64'd3);
      chk("timeout addr", 64'(err_addr_out), 64'h1010);
`else
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_in);
         chk("no-timeout err", 64'(m_err_out), 64'd0);
         chk("no-timeout cyc", 64'(s_cyc_out), 64'b010);
         @(posedge clk_in);
      end
      #1; m_cyc_in = 1'b0; m_stb_in = 1'b0;
      @(negedge clk_in);
      chk("no-timeout release", 64'(s_cyc_out), 64'd0);
`endif

      // Reset during ACTIVE; a late slave ack must not reach the master.
      @(posedge clk_in);
      #1; m_cyc_in = 1'b1; m_stb_in = 1'b1; m_adr_in = 32'h0000_1004;
      @(posedge clk_in);
      #1; reset_in = 1'b0;
      @(negedge clk_in);
      chk("mid-reset cyc/stb", 64'({s_cyc_out, s_stb_out}), 64'd0);
      chk("mid-reset ack/err/dat", 64'({m_ack_out, m_err_out, m_dat_out}), 64'd0);
      @(posedge clk_in);
      #1; s_ack_in = 3'b010;
      @(negedge clk_in);
      chk("post-reset-edge ack/err", 64'({m_ack_out, m_err_out}), 64'd0);
      @(posedge clk_in);
      #1; reset_in = 1'b1; s_ack_in = '0; m_cyc_in = 1'b0; m_stb_in = 1'b0;
      @(negedge clk_in);
      chk("reset cleared fault regs", 64'({err_cause_out, err_addr_out}), 64'd0);
      chk("reset idle cyc", 64'(s_cyc_out), 64'd0);
      xfer("rd 0x0 post-reset", 32'h0000_0000, 1'b0, 0, 1, 1'b1, 1'b0, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0);

      chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
